dmem_responder: RTL and testbench

//   Responder (memory side) of the core's req/gnt/rvalid data-memory interface.

---
 rtl/dmem_responder.sv | 99 +++++++++
 tb/tb_dmem_responder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's req/gnt/rvalid data interface: word RAM,
// fixed-latency in-order responses, read-data integrity generation and write-data integrity check.
module dmem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  input  logic        stall_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Bit i of the code folds every data bit whose index is congruent to i mod 7.
  function automatic logic [6:0] f_intg(input logic [31:0] d);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      for (int j = i; j < 32; j += 7) begin
        r[i] = r[i] ^ d[j];
      end
    end
    return r;
  endfunction

  logic [31:0]         r_mem [MEM_WORDS];
  logic [LATENCY-1:0]  r_vld;
  logic [LATENCY-1:0]  r_err;
  logic [31:0]         r_data [LATENCY];

  logic                w_gnt;
  logic [29:0]         w_word;
  logic [AW-1:0]       w_idx;
  logic                w_in_range;
  logic                w_intg_ok;
  logic                w_wr_en;
  logic                w_s0_err;
  logic [31:0]         w_s0_data;
  logic                w_unused;

  assign w_gnt      = data_req_i & ~stall_i & ~rst_i;
  assign w_word     = data_addr_i[31:2];
  assign w_idx      = w_word[AW-1:0];
  assign w_in_range = ({2'b00, w_word} < MEM_WORDS);
  assign w_intg_ok  = (f_intg(data_wdata_i) == data_wdata_intg_i);
  assign w_wr_en    = w_gnt & data_we_i & w_in_range & w_intg_ok;
  assign w_unused   = ^data_addr_i[1:0];

  assign w_s0_err  = ~w_in_range | (data_we_i & ~w_intg_ok);
  assign w_s0_data = (~data_we_i & w_in_range) ? r_mem[w_idx] : 32'h0;

  // RAM is deliberately left out of reset so accepted writes survive a pipeline flush.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) begin
          r_mem[w_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_gnt;
      r_err[0]  <= w_gnt & w_s0_err;
      r_data[0] <= w_gnt ? w_s0_data : 32'h0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_err[i]  <= r_err[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign data_gnt_o        = w_gnt;
  assign data_rvalid_o     = r_vld[LATENCY-1];
  assign data_err_o        = r_err[LATENCY-1];
  assign data_rdata_o      = r_data[LATENCY-1];
  assign data_rdata_intg_o = f_intg(r_data[LATENCY-1]);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=1 and LATENCY=3 instances share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we, stall;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic [6:0]  wintg;

  logic        gnt1, rv1, err1, gnt3, rv3, err3;
  logic [31:0] rd1, rd3;
  logic [6:0]  ri1, ri3;

  dmem_responder #(.MEM_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt1), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_wdata_intg_i(wintg),
    .stall_i(stall), .data_rvalid_o(rv1), .data_rdata_o(rd1), .data_rdata_intg_o(ri1),
    .data_err_o(err1));

  dmem_responder #(.MEM_WORDS(1024), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt3), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_wdata_intg_i(wintg),
    .stall_i(stall), .data_rvalid_o(rv3), .data_rdata_o(rd3), .data_rdata_intg_o(ri3),
    .data_err_o(err3));

  typedef struct {
    logic        rst, req, stall, we, bad;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
  } stim_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } resp_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  resp_t       q1[$], q3[$];
  logic [31:0] mmem [1024];
  logic [40:0] exp1 = '0, exp3 = '0;
  logic [32:0] log1[$], log3[$];
  resp_t       m_r;
  int          m_w;

  function automatic logic [6:0] integ(input logic [31:0] d);
    logic [6:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) r[j % 7] = r[j % 7] ^ d[j];
    return r;
  endfunction

  function automatic stim_t st(input logic r, input logic q, input logic s, input logic w,
                               input logic b, input logic [3:0] e, input logic [31:0] a,
                               input logic [31:0] d);
    stim_t x;
    x.rst = r; x.req = q; x.stall = s; x.we = w; x.bad = b; x.be = e; x.addr = a; x.wdata = d;
    return x;
  endfunction

  function automatic stim_t rd(input logic [31:0] a);
    return st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, a, 32'h0);
  endfunction

  function automatic stim_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e,
                               input logic b);
    return st(1'b0, 1'b1, 1'b0, 1'b1, b, e, a, d);
  endfunction

  function automatic stim_t idle();
    return st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endfunction

  // Reference model: a response is formed from the rules at grant time and becomes
  // due LATENCY cycles later; reset discards everything still queued.
  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      q3.delete();
    end else if (req && !stall) begin
      m_r.err  = 1'b0;
      m_r.data = 32'h0;
      m_w      = int'(addr[31:2]);
      if (addr[31:2] >= 30'd1024) m_r.err = 1'b1;
      else if (we) begin
        if (wintg !== integ(wdata)) m_r.err = 1'b1;
        else for (int k = 0; k < 4; k++) if (be[k]) mmem[m_w][8*k +: 8] = wdata[8*k +: 8];
      end else m_r.data = mmem[m_w];
      m_r.due = cyc + 1; q1.push_back(m_r);
      m_r.due = cyc + 3; q3.push_back(m_r);
    end
    cyc++;
    while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
    while (q3.size() > 0 && q3[0].due < cyc) void'(q3.pop_front());
    exp1 = (q1.size() > 0 && q1[0].due == cyc) ?
           {1'b1, q1[0].err, q1[0].data, integ(q1[0].data)} : 41'h0;
    exp3 = (q3.size() > 0 && q3[0].due == cyc) ?
           {1'b1, q3[0].err, q3[0].data, integ(q3[0].data)} : 41'h0;
  end

  task automatic drive(input stim_t s);
    rst   = s.rst;   req = s.req; stall = s.stall; we = s.we;
    be    = s.be;    addr = s.addr; wdata = s.wdata;
    wintg = integ(s.wdata) ^ {6'b0, s.bad};
  endtask

  task automatic test_reset();
    stim_t s[$];
    s.push_back(st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0));
    s.push_back(st(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h1));
    foreach (s[i]) begin
      drive(s[i]); #1;
      n_chk++;
      if ({gnt1, gnt3} !== 2'b00) begin
        n_err++; $display("FAIL reset_gnt step %0d got %b want 00", i, {gnt1, gnt3});
      end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== 82'h0) begin
        n_err++;
        $display("FAIL reset_out step %0d got %h/%h want 0", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3});
      end
    end
  endtask

  task automatic test_preload();
    stim_t s[$];
    for (int w = 0; w < 32; w++)
      s.push_back(wr(32'(w * 4), (w == 8) ? 32'h11223344 : $urandom, 4'hF, 1'b0));
    repeat (4) s.push_back(idle());
    foreach (s[i]) begin
      drive(s[i]); #1;
      n_chk++;
      if ({gnt1, gnt3} !== {2{s[i].req & ~s[i].stall & ~s[i].rst}}) begin
        n_err++; $display("FAIL preload_gnt step %0d got %b", i, {gnt1, gnt3});
      end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== {exp1, exp3}) begin
        n_err++;
        $display("FAIL preload_resp step %0d got %h/%h want %h/%h", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3}, exp1, exp3);
      end
    end
  endtask

  task automatic test_write_read();
    stim_t s[$];
    log1.delete(); log3.delete();
    s.push_back(wr(32'h10, 32'hDEADBEEF, 4'hF, 1'b0));
    s.push_back(rd(32'h10));
    repeat (4) s.push_back(idle());
    foreach (s[i]) begin
      drive(s[i]); #1;
      n_chk++;
      if ({gnt1, gnt3} !== {2{s[i].req & ~s[i].stall & ~s[i].rst}}) begin
        n_err++; $display("FAIL wr_rd_gnt step %0d got %b", i, {gnt1, gnt3});
      end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== {exp1, exp3}) begin
        n_err++;
        $display("FAIL wr_rd_resp step %0d got %h/%h want %h/%h", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3}, exp1, exp3);
      end
      if (rv1) log1.push_back({err1, rd1});
      if (rv3) log3.push_back({err3, rd3});
    end
    n_chk++;
    if (log1.size() != 2 || log1[1] !== {1'b0, 32'hDEADBEEF} || ri1 !== 7'h0) begin
      n_err++; $display("FAIL wr_rd_l1 count %0d last %h want 2 / 0deadbeef", log1.size(),
                        log1.size() > 0 ? log1[$] : 33'h0);
    end
    n_chk++;
    if (log3.size() != 2 || log3[1] !== {1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL wr_rd_l3 count %0d want 2", log3.size());
    end
  endtask

  task automatic test_byte_enable();
    stim_t s[$];
    log1.delete(); log3.delete();
    s.push_back(wr(32'h20, 32'h00AA0000, 4'b0100, 1'b0));
    s.push_back(wr(32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0));
    s.push_back(rd(32'h23));
    repeat (4) s.push_back(idle());
    foreach (s[i]) begin
      drive(s[i]); #1;
      n_chk++;
      if ({gnt1, gnt3} !== {2{s[i].req & ~s[i].stall & ~s[i].rst}}) begin
        n_err++; $display("FAIL be_gnt step %0d got %b", i, {gnt1, gnt3});
      end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== {exp1, exp3}) begin
        n_err++;
        $display("FAIL be_resp step %0d got %h/%h want %h/%h", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3}, exp1, exp3);
      end
      if (rv1) log1.push_back({err1, rd1});
      if (rv3) log3.push_back({err3, rd3});
    end
    n_chk++;
    if (log1.size() != 3 || log1[1] !== 33'h0 || log1[2] !== {1'b0, 32'h11AA3344}) begin
      n_err++; $display("FAIL be_readback count %0d last %h want 3 / 011aa3344", log1.size(),
                        log1.size() > 0 ? log1[$] : 33'h0);
    end
  endtask

  task automatic test_errors();
    stim_t s[$];
    log1.delete(); log3.delete();
    s.push_back(rd(32'h1000));
    s.push_back(wr(32'h20, 32'h55555555, 4'hF, 1'b1));
    s.push_back(wr(32'h1004, 32'h12345678, 4'hF, 1'b0));
    s.push_back(rd(32'h20));
    repeat (4) s.push_back(idle());
    foreach (s[i]) begin
      drive(s[i]); #1;
      n_chk++;
      if ({gnt1, gnt3} !== {2{s[i].req & ~s[i].stall & ~s[i].rst}}) begin
        n_err++; $display("FAIL err_gnt step %0d got %b", i, {gnt1, gnt3});
      end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== {exp1, exp3}) begin
        n_err++;
        $display("FAIL err_resp step %0d got %h/%h want %h/%h", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3}, exp1, exp3);
      end
      if (rv3) log3.push_back({err3, rd3});
    end
    n_chk++;
    if (log3.size() != 4 || log3[0] !== {1'b1, 32'h0} || log3[1] !== {1'b1, 32'h0} ||
        log3[2] !== {1'b1, 32'h0} || log3[3] !== {1'b0, 32'h11AA3344}) begin
      n_err++; $display("FAIL err_seq count %0d last %h want 4 / 011aa3344", log3.size(),
                        log3.size() > 0 ? log3[$] : 33'h0);
    end
  endtask

  task automatic test_stall();
    stim_t s[$];
    int ngnt, gstep;
    ngnt = 0; gstep = -1;
    log1.delete(); log3.delete();
    repeat (3) s.push_back(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0));
    s.push_back(rd(32'h10));
    repeat (4) s.push_back(idle());
    foreach (s[i]) begin
      drive(s[i]); #1;
      n_chk++;
      if ({gnt1, gnt3} !== {2{s[i].req & ~s[i].stall & ~s[i].rst}}) begin
        n_err++; $display("FAIL stall_gnt step %0d got %b", i, {gnt1, gnt3});
      end
      if (gnt1) begin ngnt++; gstep = i; end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== {exp1, exp3}) begin
        n_err++;
        $display("FAIL stall_resp step %0d got %h/%h want %h/%h", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3}, exp1, exp3);
      end
      if (rv1) log1.push_back({err1, rd1});
      if (rv3) log3.push_back({err3, rd3});
    end
    n_chk++;
    if (ngnt != 1 || gstep != 3 || log1.size() != 1 || log3.size() != 1) begin
      n_err++; $display("FAIL stall_once gnts %0d at %0d rv %0d/%0d want 1 at 3 rv 1/1",
                        ngnt, gstep, log1.size(), log3.size());
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    int first3, last3, cnt3;
    first3 = -1; last3 = -1; cnt3 = 0;
    for (int w = 0; w < 4; w++) s.push_back(rd(32'(w * 4)));
    repeat (5) s.push_back(idle());
    foreach (s[i]) begin
      drive(s[i]); #1;
      n_chk++;
      if ({gnt1, gnt3} !== {2{s[i].req & ~s[i].stall & ~s[i].rst}}) begin
        n_err++; $display("FAIL b2b_gnt step %0d got %b", i, {gnt1, gnt3});
      end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== {exp1, exp3}) begin
        n_err++;
        $display("FAIL b2b_resp step %0d got %h/%h want %h/%h", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3}, exp1, exp3);
      end
      if (rv3) begin
        cnt3++; last3 = i;
        if (first3 < 0) first3 = i;
      end
    end
    // After step k's edge the bench sits in cycle k+1, so cycles 3..6 are steps 2..5.
    n_chk++;
    if (cnt3 != 4 || first3 != 2 || last3 != 5) begin
      n_err++; $display("FAIL b2b_timing count %0d steps %0d..%0d want 4 steps 2..5",
                        cnt3, first3, last3);
    end
  endtask

  task automatic test_reset_inflight();
    stim_t s[$];
    log1.delete(); log3.delete();
    s.push_back(rd(32'h10));
    s.push_back(rd(32'h20));
    s.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
    repeat (5) s.push_back(idle());
    s.push_back(rd(32'h10));
    repeat (4) s.push_back(idle());
    foreach (s[i]) begin
      drive(s[i]); #1;
      n_chk++;
      if ({gnt1, gnt3} !== {2{s[i].req & ~s[i].stall & ~s[i].rst}}) begin
        n_err++; $display("FAIL rstfl_gnt step %0d got %b", i, {gnt1, gnt3});
      end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== {exp1, exp3}) begin
        n_err++;
        $display("FAIL rstfl_resp step %0d got %h/%h want %h/%h", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3}, exp1, exp3);
      end
      if (rv1) log1.push_back({err1, rd1});
      if (rv3) log3.push_back({err3, rd3});
    end
    n_chk++;
    if (log3.size() != 1 || log3[0] !== {1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL rstfl_drop l3 rvalids %0d first %h want 1 / 0deadbeef",
                        log3.size(), log3.size() > 0 ? log3[0] : 33'h0);
    end
    n_chk++;
    if (log1.size() != 3 || log1[2] !== {1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL rstfl_l1 rvalids %0d want 3", log1.size());
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 99) < 2);
      s.req   = ($urandom_range(0, 99) < 75);
      s.stall = ($urandom_range(0, 99) < 25);
      s.we    = $urandom_range(0, 1);
      s.bad   = ($urandom_range(0, 99) < 10);
      s.be    = 4'($urandom_range(0, 15));
      s.addr  = ($urandom_range(0, 99) < 10) ? 32'((1024 + $urandom_range(0, 200)) * 4)
                                              : 32'($urandom_range(0, 31) * 4);
      s.addr[1:0] = 2'($urandom_range(0, 3));
      s.wdata = $urandom;
      if (i >= 392) s = idle();
      drive(s); #1;
      n_chk++;
      if ({gnt1, gnt3} !== {2{s.req & ~s.stall & ~s.rst}}) begin
        n_err++; $display("FAIL rand_gnt step %0d got %b", i, {gnt1, gnt3});
      end
      @(posedge clk); #1;
      n_chk++;
      if ({rv1, err1, rd1, ri1, rv3, err3, rd3, ri3} !== {exp1, exp3}) begin
        n_err++;
        $display("FAIL rand_resp step %0d got %h/%h want %h/%h", i,
                 {rv1, err1, rd1, ri1}, {rv3, err3, rd3, ri3}, exp1, exp3);
      end
    end
  endtask

  initial begin
    drive(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0));
    @(posedge clk); #1;
    test_reset();
    test_preload();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
